// File: rtl/axi_noc_ingress_fifo.sv
// rtl/axi_noc_ingress_fifo.sv - NoC router ingress FWFT FIFO with occupancy/afull status.
// Optional source stability checker enabled by defining NOC_INGRESS_PROTO_CHECK_EN.
module axi_noc_ingress_fifo #(
    parameter int unsigned DATA_WIDTH   = 256,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned AFULL_THRESH = 6
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         s_valid_i,
    input  logic [DATA_WIDTH-1:0]        s_data_i,
    output logic                         s_ready_o,
    output logic                         m_valid_o,
    output logic [DATA_WIDTH-1:0]        m_data_o,
    input  logic                         m_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         afull_o,
    output logic                         err_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C   = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  afull_q, afull_d;
    logic                  push, pop;

    // Ready/valid come straight from registered occupancy: no full pass-through, no empty bypass.
    assign s_ready_o = (count_q != DEPTH_C);
    assign m_valid_o = (count_q != '0);
    assign push      = s_valid_i & s_ready_o;
    assign pop       = m_valid_o & m_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
        afull_d = (count_d >= AFULL_C);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            afull_q  <= afull_d;
        end
    end

    // Storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) mem_q[wr_ptr_q] <= s_data_i;
    end

    assign m_data_o = m_valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o  = count_q;
    assign afull_o  = afull_q;

`ifdef NOC_INGRESS_PROTO_CHECK_EN
    logic                  pend_q, pend_d;
    logic [DATA_WIDTH-1:0] cap_q, cap_d;
    logic                  err_q, err_d;
    logic                  stall;

    assign stall = s_valid_i & ~s_ready_o;

    // A stalled flit must remain valid and unchanged on the following cycle.
    always_comb begin
        pend_d = pend_q;
        cap_d  = cap_q;
        err_d  = err_q;
        if (flush_i) begin
            pend_d = 1'b0;
            err_d  = 1'b0;
        end else begin
            if (pend_q && (!s_valid_i || (s_data_i != cap_q))) err_d = 1'b1;
            if (stall) begin
                pend_d = 1'b1;
                cap_d  = s_data_i;
            end else begin
                pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= 1'b0;
            cap_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cap_q  <= cap_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi_noc_ingress_fifo.sv
// tb/tb_axi_noc_ingress_fifo.sv - directed self-checking bench for axi_noc_ingress_fifo.
module tb_axi_noc_ingress_fifo;
    localparam int DW = 256;
    localparam int DEPTH = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic          s_valid_i;
    logic [DW-1:0] s_data_i;
    logic          s_ready_o;
    logic          m_valid_o;
    logic [DW-1:0] m_data_o;
    logic          m_ready_i;
    logic [3:0]    count_o;
    logic          afull_o;
    logic          err_o;

    int n_cmp = 0;
    int n_mis = 0;

    axi_noc_ingress_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(6)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
        .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_ready_i(m_ready_i),
        .count_o(count_o), .afull_o(afull_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; s_valid_i = 1'b0; s_data_i = '0; m_ready_i = 1'b0;
        step();
        check_eq("rst_s_ready", s_ready_o, 1);
        check_eq("rst_m_valid", m_valid_o, 0);
        check_eq("rst_count", count_o, 0);
        check_eq("rst_afull", afull_o, 0);
        check_eq("rst_err", err_o, 0);
        check_eq("rst_m_data", m_data_o, 0);
        rst_ni = 1'b1;
        step();

        // Empty: m_ready ignored.
        m_ready_i = 1'b1;
        step();
        check_eq("empty_ready_count", count_o, 0);

        // Single flit, one-cycle latency.
        m_ready_i = 1'b0; s_valid_i = 1'b1; s_data_i = 'hA5;
        #1;
        check_eq("single_no_bypass", m_valid_o, 0);
        step();
        check_eq("single_valid", m_valid_o, 1);
        check_eq("single_data", m_data_o, 'hA5);
        check_eq("single_count1", count_o, 1);
        s_valid_i = 1'b0; m_ready_i = 1'b1;
        step();
        check_eq("single_count0", count_o, 0);
        check_eq("single_empty", m_valid_o, 0);

        // Fill to full with router stalled.
        m_ready_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            s_valid_i = 1'b1; s_data_i = DW'(i);
            step();
            check_eq($sformatf("fill_count%0d", i), count_o, DW'(i + 1));
            check_eq($sformatf("fill_afull%0d", i), afull_o, (i + 1 >= 6) ? 1 : 0);
            check_eq($sformatf("fill_ready%0d", i), s_ready_o, (i + 1 == DEPTH) ? 0 : 1);
        end
        s_data_i = DW'(8);
        step();
        step();
        check_eq("full_hold_count", count_o, 8);
        check_eq("full_hold_ready", s_ready_o, 0);
        check_eq("full_head", m_data_o, 0);

        // Full with simultaneous pop: no pass-through push.
        m_ready_i = 1'b1;
        step();
        check_eq("fullpop_count", count_o, 7);
        check_eq("fullpop_ready", s_ready_o, 1);
        check_eq("fullpop_head", m_data_o, 1);
        step();
        check_eq("pushpop_count", count_o, 7);
        s_valid_i = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            check_eq($sformatf("drain_data%0d", k), m_data_o, DW'(k));
            step();
        end
        check_eq("drain_count", count_o, 0);

        // Streaming across many pointer wraps.
        m_ready_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_valid_i = 1'b1; s_data_i = DW'(1000 + i);
            step();
            check_eq($sformatf("stream_count%0d", i), count_o, 1);
            check_eq($sformatf("stream_data%0d", i), m_data_o, DW'(1000 + i));
        end
        s_valid_i = 1'b0;
        step();
        check_eq("stream_end_count", count_o, 0);

        // Flush mid-burst with concurrent push.
        m_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid_i = 1'b1; s_data_i = DW'(50 + i);
            step();
        end
        check_eq("preflush_count", count_o, 5);
        flush_i = 1'b1; s_data_i = 'h55;
        step();
        flush_i = 1'b0; s_valid_i = 1'b0;
        check_eq("flush_count", count_o, 0);
        check_eq("flush_valid", m_valid_o, 0);
        check_eq("flush_ready", s_ready_o, 1);
        step();
        check_eq("flush_discard", count_o, 0);

        // Stability violation while full.
        for (int i = 0; i < DEPTH; i++) begin
            s_valid_i = 1'b1; s_data_i = DW'(200 + i);
            step();
        end
        s_data_i = 'h1;
        step();
        check_eq("proto_stall_err", err_o, 0);
        s_data_i = 'h2;
        step();
`ifdef NOC_INGRESS_PROTO_CHECK_EN
        check_eq("proto_err_set", err_o, 1);
        step();
        check_eq("proto_err_sticky", err_o, 1);
`else
        check_eq("proto_err_off", err_o, 0);
        step();
        check_eq("proto_err_off2", err_o, 0);
`endif
        flush_i = 1'b1; s_valid_i = 1'b0;
        step();
        flush_i = 1'b0;
        check_eq("proto_err_flush", err_o, 0);
        check_eq("proto_flush_count", count_o, 0);

        // Asynchronous reset mid-operation.
        s_valid_i = 1'b1; s_data_i = 'h77;
        step();
        step();
        s_valid_i = 1'b0;
        check_eq("prereset_count", count_o, 2);
        #3;
        rst_ni = 1'b0;
        #1;
        check_eq("async_rst_count", count_o, 0);
        check_eq("async_rst_valid", m_valid_o, 0);
        check_eq("async_rst_data", m_data_o, 0);
        check_eq("async_rst_ready", s_ready_o, 1);
        step();
        rst_ni = 1'b1;
        step();
        check_eq("post_rst_count", count_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/axi_noc_ingress_fifo.md
Name: axi_noc_ingress_fifo

Overview:
- Per-port ingress buffer placed directly upstream of the NoC router; one instance per router input port.
- Absorbs bursts from the source endpoint and decouples the source's valid/ready handshake from router backpressure.
- Presents a first-word-fall-through stream to the router's valid/data/ready inputs.
- Exports occupancy and almost-full status for flow-control monitoring.

Parameters:
- DATA_WIDTH, 256, flit width in bits; matches the router data width.
- DEPTH, 8, number of storage entries; power of two, minimum 2.
- AFULL_THRESH, 6, occupancy at or above which afull_o asserts; legal range 1..DEPTH.

Ports:
- clk_i  input  1  clock; all logic is rising-edge.
- rst_ni  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous flush; empties the FIFO.
- s_valid_i  input  1  source flit valid.
- s_data_i  input  DATA_WIDTH  source flit.
- s_ready_o  output  1  FIFO can accept a flit.
- m_valid_o  output  1  head flit valid toward the router.
- m_data_o  output  DATA_WIDTH  head flit.
- m_ready_i  input  1  router accepts the head flit.
- count_o  output  $clog2(DEPTH+1)  current occupancy.
- afull_o  output  1  count_o >= AFULL_THRESH.
- err_o  output  1  sticky protocol-error flag (optional feature only; otherwise tied 0).

Behaviour:
- Reset (async assert, sync deassert by the user):
  - wr_ptr, rd_ptr and count clear to 0.
  - Outputs: s_ready_o=1, m_valid_o=0, count_o=0, afull_o=0, err_o=0, m_data_o=0.
  - Storage contents are not reset.
- Pointers: $clog2(DEPTH) bits wide, wrapping naturally at DEPTH-1 -> 0. count is held separately; full means count==DEPTH, empty means count==0.
- Push: occurs when s_valid_i & s_ready_o. Writes mem[wr_ptr] and increments wr_ptr.
- Pop: occurs when m_valid_o & m_ready_i. Increments rd_ptr.
- s_ready_o = (count != DEPTH), registered-state derived. There is no pass-through when full: a pop in the same cycle does not enable a push in that cycle.
- m_valid_o = (count != 0). m_data_o = mem[rd_ptr], read combinationally from the registered pointer.
- Latency: a flit pushed into an empty FIFO appears on m_valid_o/m_data_o the next cycle. There is no same-cycle bypass.
- count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, both pointers advance.
  - neither: hold.
- afull_o is computed from the next-state count and registered, so it reflects the updated occupancy in the same cycle count_o updates.
- flush_i:
  - When high at a clock edge: pointers and count clear to 0, and any push or pop in that cycle is discarded.
  - s_ready_o=1 and m_valid_o=0 the following cycle.
  - flush_i has priority over push and pop.
- Full boundary: count==DEPTH forces s_ready_o=0. The source must hold s_valid_i/s_data_i stable until accepted.
- Empty boundary: count==0 forces m_valid_o=0. m_ready_i is ignored.
- Reset mid-operation: all contents are discarded immediately on rst_ni falling edge. Outputs take their reset values asynchronously.
- Ordering: strict FIFO; no reordering, no duplication, no drop of accepted flits.

Optional Feature:
- Macro: NOC_INGRESS_PROTO_CHECK_EN.
- Defined: a source-side AXI stability checker is compiled in.
  - It registers a pending flag and captured data whenever s_valid_i=1 and s_ready_o=0.
  - On the next cycle with the flag still set, err_o sets sticky if either s_valid_i drops, or s_data_i differs from the captured value.
  - The pending flag clears on a successful push.
  - err_o clears only on rst_ni or flush_i.
- Undefined: the checker logic is absent and err_o is tied to 0.

Test Plan:
- Reset then single flit: push 0xA5 while empty -> m_valid_o=1 with m_data_o=0xA5 exactly one cycle later; count_o goes 0->1->0 after the pop.
- Fill to full, DEPTH=8, m_ready_i=0: push 8 flits 0..7 -> s_ready_o=0 after the 8th; count_o=8; afull_o=1 from count 6; the 9th flit is held and not accepted.
- Full with simultaneous pop: count=8, s_valid_i=1, m_ready_i=1 -> that cycle pops flit 0 and pushes nothing; next cycle count=7, s_ready_o=1.
- Streaming steady state: 100 back-to-back flits with m_ready_i=1 continuously -> count_o stays at 1; output sequence is identical to input order across pointer wrap (more than 12 wraps).
- Flush mid-burst: count=5, assert flush_i for one cycle with a concurrent push -> count_o=0, m_valid_o=0 next cycle; the concurrent flit is discarded.
- Protocol violation (macro defined): stall while full, change s_data_i from 0x1 to 0x2 before acceptance -> err_o=1 next cycle and stays set until flush_i; with the macro undefined, err_o stays 0.
